// File: rtl/axis_buf_router.sv
// Counted AXI-Stream write router: a command selects one of NUM_BUF on-chip buffers, a base
// address and a beat count; accepted beats are written there with a registered, auto-incrementing address.
module axis_buf_router #(
  parameter int DMA_ADDR_BIT = 18,
  parameter int DATA_BIT     = 64,
  parameter int NUM_BUF      = 4,
  parameter int SEL_BIT      = 2,
  parameter int LEN_BIT      = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [SEL_BIT-1:0]           cmd_sel,
  input  logic [DMA_ADDR_BIT-1:0]      cmd_base_addr,
  input  logic [LEN_BIT-1:0]           cmd_len,
  input  logic [DATA_BIT-1:0]          s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [NUM_BUF*DMA_ADDR_BIT-1:0] write_addr,
  output logic [NUM_BUF*DATA_BIT-1:0]  write_data,
  output logic [NUM_BUF-1:0]           write_enable,
  output logic                         busy,
  output logic                         done,
  output logic                         err_sel,
  output logic                         err_early_last,
  output logic                         err_no_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [SEL_BIT:0]   LP_NUM_BUF = (SEL_BIT+1)'(NUM_BUF);
  localparam logic [LEN_BIT-1:0] LP_LEN_ONE = LEN_BIT'(1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [SEL_BIT-1:0]          r_sel;
  logic [DMA_ADDR_BIT-1:0]     r_base;
  logic [LEN_BIT-1:0]          r_len;
  logic [LEN_BIT-1:0]          r_cnt;

  logic                        w_cmd_ready;
  logic                        w_tready;
  logic                        w_busy;
  logic                        w_cmd_hs;
  logic                        w_sel_bad;
  logic                        w_beat;
  logic                        w_final;
  logic [NUM_BUF-1:0]          w_sel_oh;
  logic [DMA_ADDR_BIT-1:0]     w_addr_p0;

  logic [NUM_BUF-1:0]          r_wr_en_p1;
  logic [NUM_BUF*DMA_ADDR_BIT-1:0] r_wr_addr_p1;
  logic [NUM_BUF*DATA_BIT-1:0] r_wr_data_p1;
  logic                        r_done_p1;
  logic                        r_err_sel_p1;
  logic                        r_err_early_p1;
  logic                        r_err_nolast_p1;

  assign w_cmd_hs  = cmd_valid & w_cmd_ready;
  assign w_sel_bad = {1'b0, cmd_sel} >= LP_NUM_BUF;
  assign w_beat    = s_axis_tvalid & w_tready;
  assign w_final   = (r_cnt == (r_len - LP_LEN_ONE));
  // Address arithmetic is truncated to the buffer width so it wraps silently.
  assign w_addr_p0 = r_base + DMA_ADDR_BIT'(r_cnt);

  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      w_sel_oh[i] = (r_sel == SEL_BIT'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_hs) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + LP_LEN_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_cmd_hs) begin
      r_sel  <= cmd_sel;
      r_base <= cmd_base_addr;
      r_len  <= cmd_len;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_tready    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = (w_sel_bad || (cmd_len == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_tready = 1'b1;
        w_busy   = 1'b1;
        // Final counted beat or an early tlast both close the transfer.
        if (w_beat && (w_final || s_axis_tlast)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // p0 -> p1: registered write strobe, address, data and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en_p1      <= '0;
      r_wr_addr_p1    <= '0;
      r_wr_data_p1    <= '0;
      r_done_p1       <= 1'b0;
      r_err_sel_p1    <= 1'b0;
      r_err_early_p1  <= 1'b0;
      r_err_nolast_p1 <= 1'b0;
    end else begin
      r_wr_en_p1 <= w_beat ? w_sel_oh : '0;
      for (int i = 0; i < NUM_BUF; i++) begin
        r_wr_addr_p1[i*DMA_ADDR_BIT +: DMA_ADDR_BIT] <= (w_beat && w_sel_oh[i]) ? w_addr_p0 : '0;
        r_wr_data_p1[i*DATA_BIT +: DATA_BIT]         <= (w_beat && w_sel_oh[i]) ? s_axis_tdata : '0;
      end
      r_done_p1       <= (w_state_nxt == S_DONE);
      r_err_sel_p1    <= w_cmd_hs & w_sel_bad;
      r_err_early_p1  <= w_beat & s_axis_tlast & ~w_final;
      r_err_nolast_p1 <= w_beat & w_final & ~s_axis_tlast;
    end
  end

  assign cmd_ready      = w_cmd_ready;
  assign s_axis_tready  = w_tready;
  assign busy           = w_busy;
  assign write_enable   = r_wr_en_p1;
  assign write_addr     = r_wr_addr_p1;
  assign write_data     = r_wr_data_p1;
  assign done           = r_done_p1;
  assign err_sel        = r_err_sel_p1;
  assign err_early_last = r_err_early_p1;
  assign err_no_last    = r_err_nolast_p1;

endmodule

// File: tb/tb_axis_buf_router.sv
// Randomized bench for axis_buf_router (NUM_BUF=3 so select 3 is out of range); expected
// per-cycle outputs come from a transfer-level model of each command.
module tb_axis_buf_router;

  localparam int AW = 18;
  localparam int DW = 64;
  localparam int NB = 3;
  localparam int SB = 2;
  localparam int LB = 18;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [SB-1:0]     cmd_sel;
  logic [AW-1:0]     cmd_base_addr;
  logic [LB-1:0]     cmd_len;
  logic [DW-1:0]     s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [NB*AW-1:0]  write_addr;
  logic [NB*DW-1:0]  write_data;
  logic [NB-1:0]     write_enable;
  logic              busy;
  logic              done;
  logic              err_sel;
  logic              err_early_last;
  logic              err_no_last;

  int n_vec;
  int n_err;

  axis_buf_router #(
    .DMA_ADDR_BIT(AW), .DATA_BIT(DW), .NUM_BUF(NB), .SEL_BIT(SB), .LEN_BIT(LB)
  ) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .busy(busy), .done(done), .err_sel(err_sel),
    .err_early_last(err_early_last), .err_no_last(err_no_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ctl = {done, err_sel, err_early_last, err_no_last, cmd_ready, tready, busy}
  task automatic check_outs(input string tag, input int ch, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [6:0] ctl);
    logic [NB-1:0]    e_en;
    logic [NB*AW-1:0] e_addr;
    logic [NB*DW-1:0] e_data;
    e_en   = '0;
    e_addr = '0;
    e_data = '0;
    if (ch >= 0) begin
      e_en[ch]              = 1'b1;
      e_addr[ch*AW +: AW]   = a;
      e_data[ch*DW +: DW]   = d;
    end
    chk({tag, ".en"},   write_enable, e_en);
    chk({tag, ".addr"}, write_addr, e_addr);
    chk({tag, ".data"}, write_data, e_data);
    chk({tag, ".ctl"},  {done, err_sel, err_early_last, err_no_last, cmd_ready, s_axis_tready, busy}, ctl);
  endtask

  // One command. last_at: 1-based beat carrying tlast (0 = never). gap_mode: 0 none,
  // 1 one bubble before every beat, 2 random bubbles. abort_at: beat index before which rst hits (-1 none).
  task automatic do_cmd(input string tag, input logic [SB-1:0] sel, input logic [AW-1:0] base,
                        input int len, input int last_at, input int gap_mode, input int abort_at);
    bit          bad;
    int          nbeats;
    int          k;
    bit          gap;
    bit          fin;
    logic [DW-1:0] d;
    bad = (int'(sel) >= NB);
    if (bad || len == 0) nbeats = 0;
    else if (last_at > 0 && last_at < len) nbeats = last_at;
    else nbeats = len;

    cmd_valid = 1'b1; cmd_sel = sel; cmd_base_addr = base; cmd_len = LB'(len);
    cyc();
    cmd_valid = 1'b0; cmd_sel = SB'($urandom); cmd_len = LB'($urandom);
    if (nbeats == 0) begin
      check_outs({tag, ".empty_done"}, -1, '0, '0, {1'b1, bad, 2'b00, 3'b001});
      cyc();
      check_outs({tag, ".empty_idle"}, -1, '0, '0, 7'b0000_100);
      return;
    end
    check_outs({tag, ".run"}, -1, '0, '0, 7'b0000_011);

    k = 0;
    while (k < nbeats) begin
      if (k == abort_at) begin
        rst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tdata = {$urandom, $urandom};
        cyc();
        check_outs({tag, ".rst"}, -1, '0, '0, 7'b0000_100);
        rst = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        cyc();
        check_outs({tag, ".rst_idle"}, -1, '0, '0, 7'b0000_100);
        return;
      end
      gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(99) < 30);
      if (gap) begin
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'($urandom); s_axis_tdata = {$urandom, $urandom};
        cyc();
        check_outs({tag, ".gap"}, -1, '0, '0, 7'b0000_011);
        if (gap_mode == 1) gap_mode = 3;
      end
      if (gap_mode == 3) gap_mode = 1;
      d = {$urandom, $urandom};
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = (last_at == k + 1);
      fin = (k + 1 == nbeats);
      cyc();
      if (fin)
        check_outs({tag, ".last"}, int'(sel), base + AW'(k), d,
                   {1'b1, 1'b0, (k + 1 < len), (k + 1 == len) && (last_at != k + 1), 3'b001});
      else
        check_outs({tag, ".beat"}, int'(sel), base + AW'(k), d, 7'b0000_011);
      k++;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b1;
    cyc();
    check_outs({tag, ".idle"}, -1, '0, '0, 7'b0000_100);
  endtask

  initial begin
    int len;
    n_vec = 0; n_err = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_base_addr = '0; cmd_len = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (2) begin
      cyc();
      check_outs("reset", -1, '0, '0, 7'b0000_100);
    end
    rst = 1'b0;

    // stray beat with tlast while idle is not consumed
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tdata = 64'hDEAD;
    cyc();
    check_outs("idle_tlast", -1, '0, '0, 7'b0000_100);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

    do_cmd("basic",   2'd1, 18'h00100, 4, 4, 0, -1);
    do_cmd("wrap",    2'd2, 18'h3FFFE, 4, 4, 0, -1);
    do_cmd("gaps",    2'd0, 18'h01234, 8, 8, 1, -1);
    do_cmd("early",   2'd0, 18'h00200, 6, 3, 0, -1);
    do_cmd("nolast",  2'd1, 18'h00300, 2, 0, 0, -1);
    do_cmd("badsel",  2'd3, 18'h00400, 5, 5, 0, -1);
    do_cmd("empty",   2'd2, 18'h00500, 0, 0, 0, -1);
    do_cmd("abort",   2'd1, 18'h00600, 5, 5, 0, 2);
    do_cmd("fresh",   2'd1, 18'h00600, 5, 5, 0, -1);

    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(12);
      do_cmd("rand", SB'($urandom), AW'($urandom), len, $urandom_range(len + 1), 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
